// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU trace streamer.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_REG,
    ST_MEM
  } dbg_state_t;

  localparam int          HDR_WORDS   = 5;
  localparam logic [15:0] FRAME_MAGIC = 16'hA55A;

  // Total words in one snapshot frame: header, register file, data memory.
  function automatic int frame_len(input int reg_num, input int dmem_words);
    return HDR_WORDS + reg_num + dmem_words;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Advance by one when enabled, holding once the maximum is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_trace_streamer.sv
// Observation port for the pipelined CPU: counts cycles, stalls and flushes,
// and on request streams a header, the register file and data memory.
module cpu_trace_streamer
  import cpu_dbg_pkg::*;
#(
  parameter int REG_NUM    = 32,
  parameter int DMEM_WORDS = 8,
  parameter int CNT_W      = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        snap_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [2:0]  dmem_idx_o,
  input  logic [31:0] dmem_data_i,
  output logic        tx_valid_o,
  output logic [31:0] tx_data_o,
  output logic        tx_last_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int FRAME_LEN = frame_len(REG_NUM, DMEM_WORDS);
  localparam int WCNT_W    = $clog2(FRAME_LEN);

  // One running word counter spans the whole frame; section boundaries are fixed.
  localparam logic [WCNT_W-1:0] HDR_LAST  = WCNT_W'(HDR_WORDS - 1);
  localparam logic [WCNT_W-1:0] REG_FIRST = WCNT_W'(HDR_WORDS);
  localparam logic [WCNT_W-1:0] MEM_FIRST = WCNT_W'(HDR_WORDS + REG_NUM);
  localparam logic [WCNT_W-1:0] REG_LAST  = WCNT_W'(HDR_WORDS + REG_NUM - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_LEN - 1);

  dbg_state_t        state, state_next;
  logic [WCNT_W-1:0] word_cnt, word_cnt_next;
  logic              capture;
  logic              frame_done;
  logic              fire;
  logic              is_last;
  logic              overrun_set;

  logic [CNT_W-1:0]  cyc_cnt, stl_cnt, fls_cnt;
  logic [CNT_W-1:0]  cap_cyc, cap_stl, cap_fls;
  logic [31:0]       cap_pc;
  logic [7:0]        seq;

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (start_i),
    .count (cyc_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stl_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (start_i & stall_i),
    .count (stl_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fls_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (start_i & flush_i),
    .count (fls_cnt)
  );

  assign fire    = tx_valid_o & tx_ready_i;
  assign is_last = (state == ST_MEM) && (word_cnt == LAST_WORD);

  // A request while busy is an overrun, except on the edge that ends the frame.
  assign overrun_set = snap_i && (state != ST_IDLE) && !(fire && is_last);

  // Next-state logic: the word counter only moves when the sink takes a word.
  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    capture       = 1'b0;
    frame_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (snap_i) begin
          state_next    = ST_HDR;
          word_cnt_next = '0;
          capture       = 1'b1;
        end
      end
      ST_HDR: begin
        if (fire) begin
          word_cnt_next = word_cnt + WCNT_W'(1);
          if (word_cnt == HDR_LAST) state_next = ST_REG;
        end
      end
      ST_REG: begin
        if (fire) begin
          word_cnt_next = word_cnt + WCNT_W'(1);
          if (word_cnt == REG_LAST) state_next = ST_MEM;
        end
      end
      ST_MEM: begin
        if (fire) begin
          if (is_last) begin
            state_next    = ST_IDLE;
            word_cnt_next = '0;
            frame_done    = 1'b1;
          end else begin
            word_cnt_next = word_cnt + WCNT_W'(1);
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        word_cnt_next = '0;
      end
    endcase
  end

  // State and word-counter registers; reset abandons any frame in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_next;
      word_cnt <= word_cnt_next;
    end
  end

  // Freeze the counters and PC at the request edge so the header is consistent.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cap_cyc <= '0;
      cap_stl <= '0;
      cap_fls <= '0;
      cap_pc  <= '0;
    end else if (capture) begin
      cap_cyc <= cyc_cnt;
      cap_stl <= stl_cnt;
      cap_fls <= fls_cnt;
      cap_pc  <= pc_i;
    end
  end

  // Frame sequence number and the sticky overrun flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      seq       <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (frame_done) seq <= seq + 8'd1;
      if (overrun_set) overrun_o <= 1'b1;
    end
  end

  // Output mux: header from captured values, register/memory words pass through live.
  always_comb begin
    tx_valid_o = (state != ST_IDLE);
    busy_o     = (state != ST_IDLE);
    tx_last_o  = is_last;
    reg_addr_o = '0;
    dmem_idx_o = '0;
    tx_data_o  = '0;
    case (state)
      ST_HDR: begin
        case (word_cnt)
          WCNT_W'(0): tx_data_o = {FRAME_MAGIC, 8'h00, seq};
          WCNT_W'(1): tx_data_o = 32'(cap_cyc);
          WCNT_W'(2): tx_data_o = cap_pc;
          WCNT_W'(3): tx_data_o = 32'(cap_stl);
          WCNT_W'(4): tx_data_o = 32'(cap_fls);
          default:    tx_data_o = '0;
        endcase
      end
      ST_REG: begin
        reg_addr_o = 5'(word_cnt - REG_FIRST);
        tx_data_o  = reg_data_i;
      end
      ST_MEM: begin
        dmem_idx_o = 3'(word_cnt - MEM_FIRST);
        tx_data_o  = dmem_data_i;
      end
      default: begin
        tx_data_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_trace_streamer.sv
// Directed bench for cpu_trace_streamer with a register/memory model and a frame sink.
module tb_cpu_trace_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, flush, snap;
  logic [31:0] pc;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [2:0]  dmem_idx;
  logic [31:0] dmem_data;
  logic        tx_valid, tx_last, tx_ready, busy, overrun;
  logic [31:0] tx_data;

  // Second instance with narrow counters to exercise saturation.
  logic        start4, stall4, snap4, ready4;
  logic [4:0]  reg_addr4;
  logic [2:0]  dmem_idx4;
  logic        valid4, last4, busy4, overrun4;
  logic [31:0] data4;
  logic [31:0] zero32 = 32'h0;
  logic        zero1 = 1'b0;

  logic [31:0] regs [32];
  logic [7:0]  dmem [32];
  logic [31:0] expHdr [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign reg_data  = regs[reg_addr];
  assign dmem_data = {dmem[{dmem_idx, 2'b11}], dmem[{dmem_idx, 2'b10}],
                      dmem[{dmem_idx, 2'b01}], dmem[{dmem_idx, 2'b00}]};

  cpu_trace_streamer dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .pc_i(pc), .stall_i(stall),
    .flush_i(flush), .snap_i(snap), .reg_addr_o(reg_addr), .reg_data_i(reg_data),
    .dmem_idx_o(dmem_idx), .dmem_data_i(dmem_data), .tx_valid_o(tx_valid),
    .tx_data_o(tx_data), .tx_last_o(tx_last), .tx_ready_i(tx_ready),
    .busy_o(busy), .overrun_o(overrun)
  );

  cpu_trace_streamer #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start4), .pc_i(zero32), .stall_i(stall4),
    .flush_i(zero1), .snap_i(snap4), .reg_addr_o(reg_addr4), .reg_data_i(zero32),
    .dmem_idx_o(dmem_idx4), .dmem_data_i(zero32), .tx_valid_o(valid4),
    .tx_data_o(data4), .tx_last_o(last4), .tx_ready_i(ready4),
    .busy_o(busy4), .overrun_o(overrun4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expWord(input int k);
    int m;
    if (k < 5) return expHdr[k];
    if (k < 37) return regs[k-5];
    m = 4 * (k - 37);
    return {dmem[m+3], dmem[m+2], dmem[m+1], dmem[m]};
  endfunction

  task automatic setHeader(input logic [31:0] h0, h1, h2, h3, h4);
    expHdr[0] = h0; expHdr[1] = h1; expHdr[2] = h2; expHdr[3] = h3; expHdr[4] = h4;
  endtask

  // Run the CPU for a number of cycles with per-cycle stall/flush masks.
  task automatic applyStimulus(input int cycles, input logic [31:0] stallMask, input logic [31:0] flushMask);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      start = 1'b1;
      stall = stallMask[i];
      flush = flushMask[i];
    end
  endtask

  task automatic requestSnapshot();
    @(negedge clk);
    start = 1'b0; stall = 1'b0; flush = 1'b0;
    snap = 1'b1;
  endtask

  // Sink one frame. mode 0: ready always 1; mode 1: ready pattern 1,0,0,1.
  // snapAt/rstAt: word index at which to pulse snap or reset (-1 = never).
  task automatic receiveFrame(input int mode, input int snapAt, input int rstAt);
    int n = 0;
    int cyc = 0;
    bit snapDone = 0;
    bit stalled = 0;
    bit aborted = 0;
    logic [31:0] heldData = '0;
    while (n < 45 && cyc < 400) begin
      @(negedge clk);
      snap = 1'b0;
      if (n == snapAt && !snapDone) begin
        snap = 1'b1;
        snapDone = 1;
      end
      tx_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      cyc++;
      #1;
      if (n == rstAt) begin
        checkOutput("r10_addr", {27'b0, reg_addr}, 32'd10);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      checkOutput("valid", {31'b0, tx_valid}, 32'd1);
      if (stalled && n < 5) checkOutput("hdr_hold", tx_data, heldData);
      if (tx_valid && tx_ready) begin
        checkOutput($sformatf("word%0d", n), tx_data, expWord(n));
        checkOutput($sformatf("last%0d", n), {31'b0, tx_last}, 32'(n == 44));
        n++;
        stalled = 0;
      end else if (tx_valid) begin
        stalled = 1;
        heldData = tx_data;
      end
    end
    if (!aborted) begin
      checkOutput("frame_len", n, 32'd45);
      @(negedge clk);
      snap = 1'b0;
      #1;
      checkOutput("post_busy", {31'b0, busy}, 32'd0);
      checkOutput("post_valid", {31'b0, tx_valid}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    regs[8] = 32'd5;
    for (int i = 0; i < 32; i++) dmem[i] = 8'(8'h30 + i);
    dmem[0] = 8'h0A; dmem[1] = 8'h00; dmem[2] = 8'h00; dmem[3] = 8'h00;

    start = 0; stall = 0; flush = 0; snap = 0; pc = 32'd0; tx_ready = 0;
    start4 = 0; stall4 = 0; snap4 = 0; ready4 = 1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid0", {31'b0, tx_valid}, 32'd0);
    checkOutput("rst_busy0", {31'b0, busy}, 32'd0);
    checkOutput("rst_overrun0", {31'b0, overrun}, 32'd0);
    checkOutput("rst_last0", {31'b0, tx_last}, 32'd0);
    checkOutput("rst_addr0", {27'b0, reg_addr}, 32'd0);
    checkOutput("rst_idx0", {29'b0, dmem_idx}, 32'd0);
    checkOutput("rst_data0", tx_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] frame with idle CPU");
    repeat (2) @(negedge clk);
    requestSnapshot();
    setHeader(32'hA55A0000, 0, 0, 0, 0);
    receiveFrame(0, -1, -1);

    $display("[TB] counting frame, snap on last transfer edge");
    pc = 32'd32;
    applyStimulus(10, 32'b00_1001_0010, 32'b00_0010_0100);
    requestSnapshot();
    setHeader(32'hA55A0001, 10, 32, 3, 2);
    receiveFrame(0, 44, -1);
    checkOutput("no_overrun_at_last", {31'b0, overrun}, 32'd0);

    $display("[TB] backpressure frame");
    requestSnapshot();
    setHeader(32'hA55A0002, 10, 32, 3, 2);
    receiveFrame(1, -1, -1);
    checkOutput("bp_overrun", {31'b0, overrun}, 32'd0);

    $display("[TB] second request during REG");
    requestSnapshot();
    setHeader(32'hA55A0003, 10, 32, 3, 2);
    receiveFrame(0, 15, -1);
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("single_frame", {31'b0, tx_valid}, 32'd0);
    end
    checkOutput("overrun_set", {31'b0, overrun}, 32'd1);

    $display("[TB] reset mid-frame at r10");
    requestSnapshot();
    setHeader(32'hA55A0004, 10, 32, 3, 2);
    receiveFrame(0, -1, 15);
    #1;
    checkOutput("overrun_cleared", {31'b0, overrun}, 32'd0);
    checkOutput("addr_cleared", {27'b0, reg_addr}, 32'd0);
    requestSnapshot();
    setHeader(32'hA55A0000, 0, 32, 0, 0);
    receiveFrame(0, -1, -1);

    $display("[TB] saturation with 4-bit counters");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start4 = 1'b1;
      stall4 = 1'b1;
    end
    @(negedge clk);
    start4 = 1'b0; stall4 = 1'b0; snap4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      snap4 = 1'b0;
      #1;
      case (k)
        0: checkOutput("sat_h0", data4, 32'hA55A0000);
        1: checkOutput("sat_h1", data4, 32'd15);
        3: checkOutput("sat_h3", data4, 32'd15);
        4: checkOutput("sat_h4", data4, 32'd0);
        default: checkOutput("sat_valid", {31'b0, valid4}, 32'd1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
